// File: rtl/sys_bus_xfer_ctrl_pkg.sv
// Shared CPU system-bus definitions: bus width, register IDs, transfer FSM states.
package sys_bus_xfer_ctrl_pkg;

    localparam int unsigned BUS_W        = 8;
    localparam int unsigned NUM_REGS_DEF = 8;

    localparam int unsigned REG_X   = 0;
    localparam int unsigned REG_Y   = 1;
    localparam int unsigned REG_A   = 2;
    localparam int unsigned REG_SP  = 3;
    localparam int unsigned REG_B   = 4;
    localparam int unsigned REG_C   = 5;
    localparam int unsigned REG_PCL = 6;
    localparam int unsigned REG_PCH = 7;
    // One past the last register: the controller sources the immediate itself.
    localparam int unsigned REG_IMM = NUM_REGS_DEF;

    typedef enum logic [2:0] {
        StIdle,
        StDrive,
        StLatch,
        StRelease,
        StDone,
        StErr
    } xfer_state_e;

    function automatic logic xfer_illegal(input int unsigned src, input int unsigned dst,
                                          input int unsigned num_regs);
        return (dst >= num_regs) || (src > num_regs) || (src == dst);
    endfunction

endpackage

// File: rtl/sys_bus_xfer_ctrl_if.sv
// Request handshake plus per-register bus strobes between the transfer controller and the datapath.
interface sys_bus_xfer_ctrl_if #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS + 1)
);
    import sys_bus_xfer_ctrl_pkg::*;

    logic                xferValid_IN;
    logic                xferReady_OUT;
    logic [SEL_W-1:0]    srcSel_IN;
    logic [SEL_W-1:0]    dstSel_IN;
    logic [BUS_W-1:0]    immData_IN;
    logic [BUS_W-1:0]    systemBus_IN;
    logic [NUM_REGS-1:0] regWrite_EN;
    logic [NUM_REGS-1:0] regRead_EN;
    logic                xferDone_OUT;
    logic                xferError_OUT;
    logic [BUS_W-1:0]    capturedData_OUT;

    modport master (
        input  xferValid_IN, srcSel_IN, dstSel_IN, immData_IN, systemBus_IN,
        output xferReady_OUT, regWrite_EN, regRead_EN, xferDone_OUT, xferError_OUT,
               capturedData_OUT
    );

    modport slave (
        output xferValid_IN, srcSel_IN, dstSel_IN, immData_IN, systemBus_IN,
        input  xferReady_OUT, regWrite_EN, regRead_EN, xferDone_OUT, xferError_OUT,
               capturedData_OUT
    );

endinterface

// File: rtl/sys_bus_onehot_dec.sv
// Register-ID to one-hot strobe decoder; out-of-range IDs (e.g. IMM) decode to all zeros.
module sys_bus_onehot_dec #(
    parameter int unsigned NUM_REGS = 8,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS + 1)
) (
    input  logic [SEL_W-1:0]    i_idx,
    input  logic                i_en,
    output logic [NUM_REGS-1:0] o_onehot
);

    always_comb begin
        o_onehot = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            o_onehot[k] = i_en && (i_idx == SEL_W'(k));
        end
    end

endmodule

// File: rtl/sys_bus_xfer_ctrl.sv
// System-bus initiator: sequences one register-to-register (or immediate) transfer per request
// with break-before-make drive/latch strobes.
module sys_bus_xfer_ctrl
    import sys_bus_xfer_ctrl_pkg::*;
#(
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned SEL_W    = $clog2(NUM_REGS + 1)
) (
    input  logic               clk,
    input  logic               reset_N,
    sys_bus_xfer_ctrl_if.master bus,
    output logic [BUS_W-1:0]   systemBus_OUT
);

    localparam logic [SEL_W-1:0] IMM_SEL = SEL_W'(NUM_REGS);

    xfer_state_e         r_state;
    logic                r_ready;
    logic                r_done;
    logic                r_error;
    logic                r_drive_imm;
    logic [BUS_W-1:0]    r_imm;
    logic [BUS_W-1:0]    r_captured;
    logic [NUM_REGS-1:0] r_dst_oh;
    logic [NUM_REGS-1:0] r_reg_write;
    logic [NUM_REGS-1:0] r_reg_read;

    logic                w_accept;
    logic                w_illegal;
    logic [NUM_REGS-1:0] w_src_oh;
    logic [NUM_REGS-1:0] w_dst_oh;

    assign w_accept  = bus.xferValid_IN && r_ready;
    assign w_illegal = xfer_illegal(32'(bus.srcSel_IN), 32'(bus.dstSel_IN), NUM_REGS);

    sys_bus_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_wr_dec (
        .i_idx    (bus.srcSel_IN),
        .i_en     (w_accept),
        .o_onehot (w_src_oh)
    );

    sys_bus_onehot_dec #(
        .NUM_REGS (NUM_REGS),
        .SEL_W    (SEL_W)
    ) u_rd_dec (
        .i_idx    (bus.dstSel_IN),
        .i_en     (w_accept),
        .o_onehot (w_dst_oh)
    );

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state     <= StIdle;
            r_ready     <= 1'b1;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
            r_drive_imm <= 1'b0;
            r_imm       <= '0;
            r_captured  <= '0;
            r_dst_oh    <= '0;
            r_reg_write <= '0;
            r_reg_read  <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_ready <= 1'b0;
                        if (w_illegal) begin
                            r_state <= StErr;
                            r_done  <= 1'b1;
                            r_error <= 1'b1;
                        end else begin
                            r_state     <= StDrive;
                            r_reg_write <= w_src_oh;
                            r_drive_imm <= (bus.srcSel_IN == IMM_SEL);
                            r_imm       <= bus.immData_IN;
                            r_dst_oh    <= w_dst_oh;
                        end
                    end
                end
                StDrive: begin
                    r_state    <= StLatch;
                    r_reg_read <= r_dst_oh;
                end
                StLatch: begin
                    // Latch closes one cycle before the source lets go of the bus.
                    r_state    <= StRelease;
                    r_reg_read <= '0;
                    r_captured <= bus.systemBus_IN;
                end
                StRelease: begin
                    r_state     <= StDone;
                    r_reg_write <= '0;
                    r_drive_imm <= 1'b0;
                    r_done      <= 1'b1;
                end
                StDone: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_ready <= 1'b1;
                end
                StErr: begin
                    r_state <= StIdle;
                    r_done  <= 1'b0;
                    r_error <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state     <= StIdle;
                    r_ready     <= 1'b1;
                    r_done      <= 1'b0;
                    r_error     <= 1'b0;
                    r_drive_imm <= 1'b0;
                    r_reg_write <= '0;
                    r_reg_read  <= '0;
                end
            endcase
        end
    end

    assign bus.xferReady_OUT    = r_ready;
    assign bus.regWrite_EN      = r_reg_write;
    assign bus.regRead_EN       = r_reg_read;
    assign bus.xferDone_OUT     = r_done;
    assign bus.xferError_OUT    = r_error;
    assign bus.capturedData_OUT = r_captured;
    assign systemBus_OUT        = r_drive_imm ? r_imm : {BUS_W{1'bz}};

endmodule

// File: tb/tb_sys_bus_xfer_ctrl.sv
// Directed bench for sys_bus_xfer_ctrl: per-cycle strobe checks, a done/data scoreboard and
// bus invariants sampled on the falling edge.
module tb_sys_bus_xfer_ctrl;
    import sys_bus_xfer_ctrl_pkg::*;

    localparam int unsigned NR = 8;
    localparam int unsigned SW = 4;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_N;
    wire  [7:0] sys_bus_out;
    logic [7:0] reg_val [NR];
    exp_t       sb_q [$];
    exp_t       sb_e;
    int         checks = 0;
    int         errors = 0;
    int         acc_cyc [3];
    int         b2b_idx;
    int         b2b_cyc;
    int         wait_cyc;

    always #5 clk = ~clk;

    sys_bus_xfer_ctrl_if #(.NUM_REGS(NR)) bus ();

    sys_bus_xfer_ctrl #(
        .NUM_REGS (NR)
    ) dut (
        .clk           (clk),
        .reset_N       (reset_N),
        .bus           (bus),
        .systemBus_OUT (sys_bus_out)
    );

    // Resolved bus: a register drives when its write strobe is set, else the controller's pin.
    always_comb begin
        bus.systemBus_IN = sys_bus_out;
        for (int k = 0; k < NR; k++) begin
            if (bus.regWrite_EN[k]) bus.systemBus_IN = reg_val[k];
        end
    end

    // A 2-state simulator reads an undriven bus as zero; immediates used here are nonzero.
    function automatic logic released(input logic [7:0] v);
        return (v === 8'hzz) || (v === 8'h00);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input int unsigned src, input int unsigned dst,
                             input logic [7:0] imm);
        bus.xferValid_IN = 1'b1;
        bus.srcSel_IN    = SW'(src);
        bus.dstSel_IN    = SW'(dst);
        bus.immData_IN   = imm;
    endtask

    task automatic push_exp(input logic err, input logic [7:0] data);
        exp_t e;
        e.err  = err;
        e.data = data;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset_N) begin
            chk("inv_wr_onehot0", 32'($onehot0(bus.regWrite_EN)), 1);
            chk("inv_rd_onehot0", 32'($onehot0(bus.regRead_EN)), 1);
            if (|bus.regWrite_EN) chk("inv_no_contention", 32'(released(sys_bus_out)), 1);
            if (|bus.regRead_EN) begin
                chk("inv_read_single_src",
                    32'(($onehot(bus.regWrite_EN) && released(sys_bus_out)) ||
                        (bus.regWrite_EN == '0 && !released(sys_bus_out))), 1);
            end
            if (bus.xferDone_OUT) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_done", 1, 0);
                end else begin
                    sb_e = sb_q.pop_front();
                    chk("sb_error_flag", 32'(bus.xferError_OUT), 32'(sb_e.err));
                    if (!sb_e.err) chk("sb_captured", 32'(bus.capturedData_OUT), 32'(sb_e.data));
                end
            end
        end
    end

    initial begin
        reset_N          = 1'b0;
        bus.xferValid_IN = 1'b0;
        bus.srcSel_IN    = '0;
        bus.dstSel_IN    = '0;
        bus.immData_IN   = '0;
        reg_val[0]       = 8'h5A;
        for (int k = 1; k < NR; k++) reg_val[k] = {4'(k), 4'(k)};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus.xferReady_OUT), 1);
        chk("rst_write", 32'(bus.regWrite_EN), 0);
        chk("rst_read", 32'(bus.regRead_EN), 0);
        chk("rst_done", 32'(bus.xferDone_OUT), 0);
        chk("rst_error", 32'(bus.xferError_OUT), 0);
        chk("rst_captured", 32'(bus.capturedData_OUT), 0);
        chk("rst_bus_released", 32'(released(sys_bus_out)), 1);
        @(negedge clk) reset_N = 1'b1;
        step();

        // Reset during LATCH: enables drop at once, no done pulse afterwards
        drive_req(REG_X, REG_Y, 8'h00);
        step();
        bus.xferValid_IN = 1'b0;
        chk("mid_t1_write", 32'(bus.regWrite_EN), 32'h01);
        step();
        chk("mid_t2_read", 32'(bus.regRead_EN), 32'h02);
        #2 reset_N = 1'b0;
        #1;
        chk("mid_rst_write", 32'(bus.regWrite_EN), 0);
        chk("mid_rst_read", 32'(bus.regRead_EN), 0);
        chk("mid_rst_done", 32'(bus.xferDone_OUT), 0);
        @(negedge clk) reset_N = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_no_done", 32'(bus.xferDone_OUT), 0);
        end
        chk("mid_ready_after", 32'(bus.xferReady_OUT), 1);
        chk("mid_captured_kept", 32'(bus.capturedData_OUT), 0);

        // Register to register: X -> Y
        drive_req(REG_X, REG_Y, 8'hFF);
        push_exp(1'b0, 8'h5A);
        step();
        bus.xferValid_IN = 1'b0;
        chk("r2r_t1_write", 32'(bus.regWrite_EN), 32'h01);
        chk("r2r_t1_read", 32'(bus.regRead_EN), 0);
        chk("r2r_t1_ready", 32'(bus.xferReady_OUT), 0);
        chk("r2r_t1_bus_released", 32'(released(sys_bus_out)), 1);
        step();
        chk("r2r_t2_write", 32'(bus.regWrite_EN), 32'h01);
        chk("r2r_t2_read", 32'(bus.regRead_EN), 32'h02);
        step();
        chk("r2r_t3_write", 32'(bus.regWrite_EN), 32'h01);
        chk("r2r_t3_read", 32'(bus.regRead_EN), 0);
        chk("r2r_t3_captured", 32'(bus.capturedData_OUT), 32'h5A);
        step();
        chk("r2r_t4_write", 32'(bus.regWrite_EN), 0);
        chk("r2r_t4_done", 32'(bus.xferDone_OUT), 1);
        chk("r2r_t4_error", 32'(bus.xferError_OUT), 0);
        chk("r2r_t4_ready", 32'(bus.xferReady_OUT), 0);
        step();
        chk("r2r_t5_ready", 32'(bus.xferReady_OUT), 1);
        chk("r2r_t5_done", 32'(bus.xferDone_OUT), 0);

        // Immediate into A
        drive_req(REG_IMM, REG_A, 8'hC3);
        push_exp(1'b0, 8'hC3);
        step();
        bus.xferValid_IN = 1'b0;
        chk("imm_t1_bus", 32'(sys_bus_out), 32'hC3);
        chk("imm_t1_write", 32'(bus.regWrite_EN), 0);
        chk("imm_t1_read", 32'(bus.regRead_EN), 0);
        step();
        chk("imm_t2_bus", 32'(sys_bus_out), 32'hC3);
        chk("imm_t2_read", 32'(bus.regRead_EN), 32'h04);
        step();
        chk("imm_t3_bus", 32'(sys_bus_out), 32'hC3);
        chk("imm_t3_read", 32'(bus.regRead_EN), 0);
        chk("imm_t3_captured", 32'(bus.capturedData_OUT), 32'hC3);
        step();
        chk("imm_t4_bus_released", 32'(released(sys_bus_out)), 1);
        chk("imm_t4_done", 32'(bus.xferDone_OUT), 1);
        step();
        chk("imm_t5_ready", 32'(bus.xferReady_OUT), 1);

        // Errors: src==dst, then dst out of range
        for (int t = 0; t < 2; t++) begin
            if (t == 0) drive_req(REG_SP, REG_SP, 8'h00);
            else        drive_req(REG_X, REG_IMM, 8'h00);
            push_exp(1'b1, 8'h00);
            step();
            bus.xferValid_IN = 1'b0;
            chk("err_t1_done", 32'(bus.xferDone_OUT), 1);
            chk("err_t1_error", 32'(bus.xferError_OUT), 1);
            chk("err_t1_write", 32'(bus.regWrite_EN), 0);
            chk("err_t1_read", 32'(bus.regRead_EN), 0);
            chk("err_t1_ready", 32'(bus.xferReady_OUT), 0);
            chk("err_t1_bus_released", 32'(released(sys_bus_out)), 1);
            step();
            chk("err_t2_ready", 32'(bus.xferReady_OUT), 1);
            chk("err_t2_done", 32'(bus.xferDone_OUT), 0);
            chk("err_t2_error", 32'(bus.xferError_OUT), 0);
        end
        chk("err_captured_kept", 32'(bus.capturedData_OUT), 32'hC3);

        // Back-to-back with valid held high; selects scrambled while busy
        b2b_idx = 0;
        b2b_cyc = 0;
        bus.xferValid_IN = 1'b1;
        while (b2b_idx < 3 && b2b_cyc < 60) begin
            if (bus.xferReady_OUT) begin
                acc_cyc[b2b_idx] = b2b_cyc;
                case (b2b_idx)
                    0: begin drive_req(1, 2, 8'h00); push_exp(1'b0, 8'h11); end
                    1: begin drive_req(4, 5, 8'h00); push_exp(1'b0, 8'h44); end
                    default: begin drive_req(REG_IMM, REG_X, 8'h7E); push_exp(1'b0, 8'h7E); end
                endcase
                b2b_idx++;
            end else begin
                bus.srcSel_IN  = SW'($urandom_range(0, 15));
                bus.dstSel_IN  = SW'($urandom_range(0, 15));
                bus.immData_IN = 8'($urandom_range(0, 255));
            end
            step();
            b2b_cyc++;
        end
        for (int i = 0; i < 3; i++) begin
            bus.srcSel_IN  = SW'($urandom_range(0, 15));
            bus.dstSel_IN  = SW'($urandom_range(0, 15));
            bus.immData_IN = 8'($urandom_range(0, 255));
            step();
        end
        bus.xferValid_IN = 1'b0;
        chk("b2b_all_accepted", 32'(b2b_idx), 3);
        chk("b2b_gap_0_1", 32'(acc_cyc[1] - acc_cyc[0]), 5);
        chk("b2b_gap_1_2", 32'(acc_cyc[2] - acc_cyc[1]), 5);

        wait_cyc = 0;
        while (sb_q.size() != 0 && wait_cyc < 20) begin
            step();
            wait_cyc++;
        end
        step();
        chk("sb_drained", 32'(sb_q.size()), 0);
        chk("end_ready", 32'(bus.xferReady_OUT), 1);
        chk("end_captured", 32'(bus.capturedData_OUT), 32'h7E);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sys_bus_xfer_ctrl.md
Name: sys_bus_xfer_ctrl

Overview:
Initiator side of the CPU internal 8-bit tri-state system bus. It sequences one register-to-register transfer per request by driving the per-register systemBusWrite_EN (drive bus) and systemBusRead_EN (latch from bus) strobes that the register blocks (X, Y, A, ...) respond to. The enables follow a fixed break-before-make order so a latch-style destination never captures a floating bus. The block can also source an 8-bit immediate onto the bus itself.

Parameters:
NUM_REGS, 8, number of attached bus registers; register IDs are 0..NUM_REGS-1
SEL_W, $clog2(NUM_REGS+1), width of the source/destination selects; ID value NUM_REGS means the immediate (IMM)

Ports:
clk  input  1  system clock, all state on the rising edge
reset_N  input  1  asynchronous active-low reset
xferValid_IN  input  1  transfer request valid
xferReady_OUT  output  1  controller can accept a request
srcSel_IN  input  SEL_W  source ID (0..NUM_REGS-1, or NUM_REGS for IMM)
dstSel_IN  input  SEL_W  destination ID (0..NUM_REGS-1)
immData_IN  input  8  immediate value, sampled at request acceptance
systemBus_IN  input  8  resolved system bus value
systemBus_OUT  output  8  immediate drive onto the bus; 'z when not driving
regWrite_EN  output  NUM_REGS  one-hot at most: register k drives the bus
regRead_EN  output  NUM_REGS  one-hot at most: register k latches the bus
xferDone_OUT  output  1  one-cycle pulse at transfer completion
xferError_OUT  output  1  qualifies xferDone_OUT: the request was rejected
capturedData_OUT  output  8  bus value sampled during the last good transfer

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; regWrite_EN=0; regRead_EN=0; systemBus_OUT='z; xferDone_OUT=0; xferError_OUT=0; capturedData_OUT=8'h00.
- Reset mid-transfer: all enables drop in the same instant reset asserts; the pending transfer is abandoned and no done pulse is produced.
- All enable and status outputs are registered. xferReady_OUT=1 only in IDLE.
- Acceptance: the handshake xferValid_IN && xferReady_OUT at rising edge T0 latches srcSel_IN, dstSel_IN and immData_IN.
- Errors: dstSel_IN >= NUM_REGS, srcSel_IN > NUM_REGS, or srcSel_IN==dstSel_IN.
  - The block goes to ERR for one cycle with xferDone_OUT=1 and xferError_OUT=1.
  - No enable is asserted and the bus is not driven. The next state is IDLE.
- Good transfer states, where Tn is the cycle after edge n:
  - DRIVE (T1): regWrite_EN[src]=1, or systemBus_OUT=imm when src==IMM.
  - LATCH (T2): source still driving, and regRead_EN[dst]=1.
  - RELEASE (T3): regRead_EN=0 while the source is still driving (hold margin for the latch). capturedData_OUT takes the systemBus_IN value sampled at the edge ending LATCH.
  - DONE (T4): all enables=0, systemBus_OUT='z, xferDone_OUT=1, xferError_OUT=0.
  - IDLE (T5): xferReady_OUT=1.
- Latency: done pulse 4 cycles after acceptance. Minimum request spacing is 5 cycles for good transfers and 2 cycles for errors.
- Invariants that hold every cycle:
  - $onehot0(regWrite_EN).
  - $onehot0(regRead_EN).
  - The controller never drives systemBus_OUT while any regWrite_EN bit is set.
  - regRead_EN is nonzero only when exactly one bus source is active.
  - regRead_EN rises at least one cycle after its source starts driving and falls at least one cycle before the source stops.
- xferValid_IN outside IDLE is ignored, not queued.
- xferValid_IN with changing selects while ready=0 has no effect.

Decomposition:
- Shared CPU bus package holds:
  - the state enum typedef (IDLE, DRIVE, LATCH, RELEASE, DONE, ERR);
  - the register-ID constants (X, Y, A, SP, ... and IMM=NUM_REGS);
  - localparam BUS_W=8.
- One natural sub-module, sys_bus_onehot_dec: SEL_W index plus enable in, NUM_REGS one-hot out. It is instantiated twice, once for write and once for read.
- The FSM stays in the top module.

Test Plan:
- Reset mid-operation: request src=0(X), dst=1, then assert reset_N=0 during LATCH. Required: all enables 0 immediately, no done pulse, ready=1 after release.
- Register to register: src=0(X), dst=1(Y), bus model returns 8'h5A while X drives. Required:
  - regWrite_EN=8'b0000_0001 during T1-T3;
  - regRead_EN=8'b0000_0010 during T2 only;
  - done at T4;
  - capturedData_OUT=8'h5A.
- Immediate: src=IMM(8), dst=2, imm=8'hC3. Required: systemBus_OUT=8'hC3 during T1-T3 and 'z otherwise, regWrite_EN=0 throughout, regRead_EN[2] high during T2 only, capturedData_OUT=8'hC3.
- Errors: src=3,dst=3, then dst=8. Required: each gives one cycle with done=1 and error=1, no enables ever asserted, ready back 2 cycles after acceptance.
- Back-to-back: valid held high with 3 queued requests. Required: acceptances exactly 5 cycles apart, extra valid cycles ignored, and the onehot0 and read-inside-write assertions never fire.
